// File: rtl/keypad_pkg.sv
// Shared constants, row-state encoding and bit-vector helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_e;

    function automatic logic [3:0] onehot_index(input logic [KP_KEYS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic popcount_gt1(input logic [KP_KEYS-1:0] v);
        logic seen;
        logic gt;
        seen = 1'b0;
        gt   = 1'b0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (v[i]) begin
                gt   = gt | seen;
                seen = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/kp_col_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad column lines.
module kp_col_sync
    import keypad_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_col_n,
    output logic [3:0] o_col_sync
);

    logic [3:0] r_meta;

    // Idle columns read high, so both stages reset to all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta     <= 4'b1111;
            o_col_sync <= 4'b1111;
        end else begin
            r_meta     <= i_col_n;
            o_col_sync <= r_meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, frame assembly, multi-key filter, frame debounce.
// Define KEYPAD_LATCH_EN to hold the last pressed key on keyin across releases.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [3:0]          row_n,
    input  logic [3:0]          col_n,
    output logic [KP_KEYS-1:0]  keyin,
    output logic                key_valid,
    output logic [3:0]          key_code
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_FRAMES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_FRAMES - 1);

    row_state_e          r_state;
    logic [DIV_W-1:0]    r_div;
    logic [11:0]         r_snap;
    logic [KP_KEYS-1:0]  r_prev;
    logic [STAB_W-1:0]   r_stab;
`ifdef KEYPAD_LATCH_EN
    logic                r_released;
`endif

    logic [3:0]          w_col_sync;
    logic [3:0]          w_col;
    logic [KP_KEYS-1:0]  w_frame;
    logic [KP_KEYS-1:0]  w_filt;
    logic                w_sample;

    kp_col_sync u_sync (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_col_n    (col_n),
        .o_col_sync (w_col_sync)
    );

    // Row 3's columns join the frame combinationally on the frame-end edge.
    assign w_col    = ~w_col_sync;
    assign w_frame  = {w_col, r_snap};
    assign w_filt   = popcount_gt1(w_frame) ? {KP_KEYS{1'b0}} : w_frame;
    assign w_sample = (r_div == DIV_LAST);

    // Row scan FSM with snapshot, debounce and commit of the key word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ROW0;
            row_n      <= ROW_RESET;
            r_div      <= {DIV_W{1'b0}};
            r_snap     <= 12'h000;
            r_prev     <= {KP_KEYS{1'b0}};
            r_stab     <= {STAB_W{1'b0}};
            keyin      <= {KP_KEYS{1'b0}};
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
`ifdef KEYPAD_LATCH_EN
            r_released <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (!w_sample) begin
                r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
            end else begin
                r_div <= {DIV_W{1'b0}};
                case (r_state)
                    ROW0: begin
                        r_snap[3:0] <= w_col;
                        r_state     <= ROW1;
                        row_n       <= 4'b1101;
                    end
                    ROW1: begin
                        r_snap[7:4] <= w_col;
                        r_state     <= ROW2;
                        row_n       <= 4'b1011;
                    end
                    ROW2: begin
                        r_snap[11:8] <= w_col;
                        r_state      <= ROW3;
                        row_n        <= 4'b0111;
                    end
                    ROW3: begin
                        r_state <= ROW0;
                        row_n   <= ROW_RESET;
                        if (w_filt != r_prev) begin
                            r_prev <= w_filt;
                            r_stab <= {STAB_W{1'b0}};
                        end else if (r_stab < STAB_MAX) begin
                            r_stab <= r_stab + {{(STAB_W-1){1'b0}}, 1'b1};
                            if (r_stab == STAB_LAST) begin
`ifdef KEYPAD_LATCH_EN
                                if (w_filt == {KP_KEYS{1'b0}}) begin
                                    r_released <= 1'b1;
                                end else if ((w_filt != keyin) || r_released) begin
                                    keyin      <= w_filt;
                                    key_valid  <= 1'b1;
                                    key_code   <= onehot_index(w_filt);
                                    r_released <= 1'b0;
                                end else begin
                                    r_released <= 1'b0;
                                end
`else
                                keyin <= w_filt;
                                if ((w_filt != {KP_KEYS{1'b0}}) && (w_filt != keyin)) begin
                                    key_valid <= 1'b1;
                                    key_code  <= onehot_index(w_filt);
                                end else begin
                                    key_valid <= 1'b0;
                                end
`endif
                            end else begin
                                key_valid <= 1'b0;
                            end
                        end else begin
                            r_stab <= r_stab;
                        end
                    end
                    default: begin
                        r_state <= ROW0;
                        row_n   <= ROW_RESET;
                    end
                endcase
            end
        end
    end

endmodule
